// File: rtl/param_circular_fifo_pkg.sv
// Shared defaults and operation encoding for the parameterised circular FIFO.
// Define FIFO_ERR_FLAGS_EN at compile time to add the sticky OVERFLOW/UNDERFLOW outputs.
package param_circular_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_AF_OFFSET  = 4;   // ALMOST_FULL threshold sits this far below DEPTH
  localparam int DEF_AE_THRESH  = 2;

  // Accepted operation on a given edge, encoded as {wr_acc, rd_acc}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_mem_1r1w.sv
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// synchronous read port; the read register clears on rst, the array does not.
module fifo_mem_1r1w #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose; clearing it would turn it into a
  // huge reset fan-out for no functional gain, since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: non-blocking assignment makes a same-address read and write on one
  // edge return the old word, which the full-and-both-strobes case relies on.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_circular_fifo.sv
// Synchronous circular FIFO with fill level and programmable almost flags.
// Optional sticky OVERFLOW/UNDERFLOW outputs when FIFO_ERR_FLAGS_EN is defined.
module param_circular_fifo
  import param_circular_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int AF_THRESH  = DEPTH - DEF_AF_OFFSET,
  parameter  int AE_THRESH  = DEF_AE_THRESH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  FCLK,
  input  logic                  FRST,
  input  logic                  WR_EN,
  input  logic                  RD_EN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  ALMOST_EMPTY,
  output logic                  ALMOST_FULL,
  output logic [ADDR_WIDTH:0]   COUNT
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
`endif
);

  localparam logic [ADDR_WIDTH:0] ONE    = 1;
  localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH + 1)'(AE_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_circular_fifo: DEPTH must be a power of two >= 2");
  end
  if (!(AE_THRESH >= 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("param_circular_fifo: thresholds must satisfy 0 <= AE < AF <= DEPTH");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, count_q;
  logic                wr_acc, rd_acc;
  fifo_op_e            op;

  assign EMPTY        = (wr_ptr == rd_ptr);
  assign FULL         = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                        (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign ALMOST_EMPTY = (count_q <= AE_CNT);
  assign ALMOST_FULL  = (count_q >= AF_CNT);
  assign COUNT        = count_q;

  // A write into a full FIFO is allowed only when a read frees the head slot.
  assign wr_acc = WR_EN & (~FULL | RD_EN);
  assign rd_acc = RD_EN & ~EMPTY;
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  always_ff @(posedge FCLK) begin
    if (FRST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      case (op)
        OP_WR:   count_q <= count_q + ONE;
        OP_RD:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge FCLK) begin
    if (FRST) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (WR_EN && FULL && !RD_EN) OVERFLOW  <= 1'b1;
      if (RD_EN && EMPTY)          UNDERFLOW <= 1'b1;
    end
  end
`endif

  fifo_mem_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (FCLK),
    .rst   (FRST),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (DATA_IN),
    .re    (rd_acc),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (DATA_OUT)
  );

endmodule

// File: tb/tb_param_circular_fifo.sv
// Self-checking bench for param_circular_fifo (DATA_WIDTH=8, DEPTH=16, AF=12, AE=2):
// vector table, directed boundary sequences and random traffic against a queue model.
module tb_param_circular_fifo;

  logic       FCLK = 1'b0;
  logic       FRST, WR_EN, RD_EN;
  logic [7:0] DATA_IN, DATA_OUT;
  logic       EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL;
  logic [4:0] COUNT;
`ifdef FIFO_ERR_FLAGS_EN
  logic       OVERFLOW, UNDERFLOW;
`endif

  param_circular_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .AF_THRESH  (12),
    .AE_THRESH  (2)
  ) dut (
    .FCLK         (FCLK),
    .FRST         (FRST),
    .WR_EN        (WR_EN),
    .RD_EN        (RD_EN),
    .DATA_IN      (DATA_IN),
    .DATA_OUT     (DATA_OUT),
    .EMPTY        (EMPTY),
    .FULL         (FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .ALMOST_FULL  (ALMOST_FULL),
    .COUNT        (COUNT)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .OVERFLOW     (OVERFLOW),
    .UNDERFLOW    (UNDERFLOW)
`endif
  );

  always #5 FCLK = ~FCLK;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue of stored words plus the last word read out.
  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_ovf, m_unf;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] din;
    int         count;
    logic [7:0] dout;
    bit         empty;
    bit         full;
    bit         ae;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic step(input bit wr, input bit rd, input logic [7:0] din);
    bit full_now, empty_now;
    @(negedge FCLK);
    WR_EN   = wr;
    RD_EN   = rd;
    DATA_IN = din;
    @(posedge FCLK);
    full_now  = (q.size() == 16);
    empty_now = (q.size() == 0);
    if (wr && full_now && !rd) m_ovf = 1'b1;
    if (rd && empty_now)       m_unf = 1'b1;
    if (rd && !empty_now)      m_dout = q.pop_front();
    if (wr && (!full_now || rd)) q.push_back(din);
    #1;
  endtask

  task automatic do_reset();
    @(negedge FCLK);
    FRST    = 1'b1;
    WR_EN   = 1'b1;
    RD_EN   = 1'b0;
    DATA_IN = 8'h99;
    repeat (2) @(posedge FCLK);
    model_reset();
    @(negedge FCLK);
    FRST  = 1'b0;
    WR_EN = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, 32'(COUNT), 32'(q.size()));
    check({tag, ".dout"},  32'(DATA_OUT), 32'(m_dout));
    check({tag, ".empty"}, 32'(EMPTY), 32'(q.size() == 0));
    check({tag, ".full"},  32'(FULL), 32'(q.size() == 16));
    check({tag, ".ae"},    32'(ALMOST_EMPTY), 32'(q.size() <= 2));
    check({tag, ".af"},    32'(ALMOST_FULL), 32'(q.size() >= 12));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, ".ovf"},   32'(OVERFLOW), 32'(m_ovf));
    check({tag, ".unf"},   32'(UNDERFLOW), 32'(m_unf));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    FRST = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; DATA_IN = 8'h00;
    model_reset();

    //                wr rd din   cnt dout  emp full ae
    vecs[0]  = '{1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 8'h55, 1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 8'h11, 2, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 1, 8'h55, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 8'h22, 1, 8'h11, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 0, 8'h22, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 0, 8'h22, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 8'h33, 1, 8'h22, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 8'h44, 2, 8'h22, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h66, 3, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 2, 8'h33, 1'b0, 1'b0, 1'b1};

    // Reset held with WR_EN high must leave the FIFO empty and DATA_OUT cleared.
    do_reset();
    check("reset.empty", 32'(EMPTY), 32'd1);
    check("reset.full",  32'(FULL), 32'd0);
    check("reset.count", 32'(COUNT), 32'd0);
    check("reset.ae",    32'(ALMOST_EMPTY), 32'd1);
    check("reset.af",    32'(ALMOST_FULL), 32'd0);
    check("reset.dout",  32'(DATA_OUT), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("reset.ovf",   32'(OVERFLOW), 32'd0);
    check("reset.unf",   32'(UNDERFLOW), 32'd0);
`endif

    // Table of short sequences around the empty boundary.
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("vec%0d.count", i), 32'(COUNT), 32'(vecs[i].count));
      check($sformatf("vec%0d.dout", i),  32'(DATA_OUT), 32'(vecs[i].dout));
      check($sformatf("vec%0d.empty", i), 32'(EMPTY), 32'(vecs[i].empty));
      check($sformatf("vec%0d.full", i),  32'(FULL), 32'(vecs[i].full));
      check($sformatf("vec%0d.ae", i),    32'(ALMOST_EMPTY), 32'(vecs[i].ae));
    end

    // Fill 0x00..0x0F, tracking where the almost flags change.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      check($sformatf("fill%0d.af", i), 32'(ALMOST_FULL), 32'(i + 1 >= 12));
      check($sformatf("fill%0d.ae", i), 32'(ALMOST_EMPTY), 32'(i + 1 <= 2));
    end
    check("fill.full",  32'(FULL), 32'd1);
    check("fill.count", 32'(COUNT), 32'd16);

    // Write while full is dropped.
    step(1'b1, 1'b0, 8'hEE);
    check("ovf_wr.count", 32'(COUNT), 32'd16);
`ifdef FIFO_ERR_FLAGS_EN
    check("ovf_wr.flag",  32'(OVERFLOW), 32'd1);
`endif

    // Simultaneous read and write while full: head out, new word at tail.
    step(1'b1, 1'b1, 8'h10);
    check("full_both.dout",  32'(DATA_OUT), 32'h00);
    check("full_both.count", 32'(COUNT), 32'd16);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("drain%0d.dout", i), 32'(DATA_OUT), 32'(i + 1));
    end
    check("drain.empty", 32'(EMPTY), 32'd1);
    check_model("drain");

    // Read while empty leaves DATA_OUT alone.
    step(1'b0, 1'b1, 8'h00);
    check("unf_rd.dout",  32'(DATA_OUT), 32'h10);
    check("unf_rd.count", 32'(COUNT), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("unf_rd.flag",  32'(UNDERFLOW), 32'd1);
    check("unf_rd.ovf_sticky", 32'(OVERFLOW), 32'd1);
`endif

    // Both strobes while empty: only the write is taken.
    step(1'b1, 1'b1, 8'h55);
    check("empty_both.count", 32'(COUNT), 32'd1);
    check("empty_both.empty", 32'(EMPTY), 32'd0);
    check("empty_both.dout",  32'(DATA_OUT), 32'h10);
    step(1'b0, 1'b1, 8'h00);
    check("empty_both.read",  32'(DATA_OUT), 32'h55);

    // Wrap-around with pointers displaced from zero.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
    check_model("wrap_pre");
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'hA0 + i));
    check("wrap.full", 32'(FULL), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("wrap%0d.dout", i), 32'(DATA_OUT), 32'(8'hA0 + i));
    end
    check_model("wrap_post");

    // Reset clears error flags and discards data.
    do_reset();
    check_model("reset2");

    // Random traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 600; i++) begin
      int wbias;
      wbias = ((i / 60) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < wbias, $urandom_range(0, 99) < (100 - wbias),
           8'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
